// File: rtl/fwd_scoreboard_pkg.sv
// Shared register-file addressing types for the forwarding scoreboard.
// The same types are used by the top level and by the per-port operand mux.
package fwd_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue-stage bus between the pipeline (master) and the scoreboard (slave).
// The flat per-stage and per-port fields are packed with index 0 in the low bits.
interface fwd_scoreboard_if #(
  parameter int NUM_RD   = 2,
  parameter int NUM_FWD  = 2,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
);
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  logic [NUM_FWD-1:0]        fwd_en;
  logic [NUM_FWD*5-1:0]      fwd_addr;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic [NUM_RD-1:0]         rd_used;
  logic [NUM_RD*5-1:0]       rd_addr;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD*DATA_W-1:0]  rd_value;
  logic                      iss_valid;
  logic                      iss_long;
  logic [4:0]                iss_dst;
  logic                      wb_en;
  logic [4:0]                wb_addr;
  logic [DATA_W-1:0]         wb_data;
  logic                      stall;
  logic [CNT_W-1:0]          pend_cnt;
  logic [31:0]               stall_cycles;

  modport master (
    output fwd_en, fwd_addr, fwd_data, fwd_ready,
    output rd_used, rd_addr, rd_data,
    output iss_valid, iss_long, iss_dst,
    output wb_en, wb_addr, wb_data,
    input  rd_value, stall, pend_cnt, stall_cycles
  );

  modport slave (
    input  fwd_en, fwd_addr, fwd_data, fwd_ready,
    input  rd_used, rd_addr, rd_data,
    input  iss_valid, iss_long, iss_dst,
    input  wb_en, wb_addr, wb_data,
    output rd_value, stall, pend_cnt, stall_cycles
  );

endinterface

// File: rtl/fwd_port_mux.sv
// One read port: picks the youngest forwarded value (then writeback, then regfile)
// and flags a hazard when that source is not yet available.
module fwd_port_mux
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int DATA_W  = 32
) (
  input  logic                       rd_used,
  input  reg_addr_t                  rd_addr,
  input  logic [DATA_W-1:0]          rd_data,
  input  logic [NUM_FWD-1:0]         fwd_en,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  input  logic [NUM_FWD-1:0]         fwd_ready,
  input  logic                       wb_en,
  input  reg_addr_t                  wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [NUM_REGS-1:0]        pending,
  output logic [DATA_W-1:0]          value,
  output logic                       hazard
);

  logic fwd_hit;
  logic fwd_hit_ready;
  logic wb_hit;

  always_comb begin
    value         = rd_data;
    fwd_hit       = 1'b0;
    fwd_hit_ready = 1'b1;
    wb_hit        = wb_en && (wb_addr == rd_addr);
    if (wb_hit) begin
      value = wb_data;
    end
    // Walk oldest to youngest so the lowest matching index wins.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_en[i] && (fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == rd_addr)) begin
        fwd_hit       = 1'b1;
        fwd_hit_ready = fwd_ready[i];
        value         = fwd_data[i*DATA_W +: DATA_W];
      end
    end
    if (rd_addr == ZERO_REG) begin
      value = '0;
    end
    // A matching stage that is not ready blocks; older sources are never consulted.
    hazard = rd_used && (rd_addr != ZERO_REG) &&
             (fwd_hit ? !fwd_hit_ready : (pending[rd_addr] && !wb_hit));
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and long-latency pending-register scoreboard for the issue stage.
// Tracks outstanding mul/div destinations and raises stall on RAW/WAW or full tracker.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_RD   = 2,
  parameter int NUM_FWD  = 2,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input logic             clk,
  input logic             rst,
  fwd_scoreboard_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;

  logic [DATA_W-1:0]   port_value [NUM_RD];
  logic [NUM_RD-1:0]   port_hazard;
  logic                long_block;
  logic                stall;
  logic                accept_long;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
    fwd_port_mux #(
      .NUM_FWD (NUM_FWD),
      .DATA_W  (DATA_W)
    ) u_mux (
      .rd_used   (bus.rd_used[gi]),
      .rd_addr   (bus.rd_addr[gi*REG_ADDR_W +: REG_ADDR_W]),
      .rd_data   (bus.rd_data[gi*DATA_W +: DATA_W]),
      .fwd_en    (bus.fwd_en),
      .fwd_addr  (bus.fwd_addr),
      .fwd_data  (bus.fwd_data),
      .fwd_ready (bus.fwd_ready),
      .wb_en     (bus.wb_en),
      .wb_addr   (bus.wb_addr),
      .wb_data   (bus.wb_data),
      .pending   (pending_q),
      .value     (port_value[gi]),
      .hazard    (port_hazard[gi])
    );
  end

  always_comb begin
    bus.rd_value = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      bus.rd_value[j*DATA_W +: DATA_W] = port_value[j];
    end
  end

  always_comb begin
    // A same-cycle writeback frees either the destination or a tracker slot.
    long_block = bus.iss_long &&
                 ((pending_q[bus.iss_dst] && !(bus.wb_en && (bus.wb_addr == bus.iss_dst))) ||
                  ((pend_cnt_q == CNT_W'(MAX_PEND)) && !bus.wb_en));
    stall       = !rst && bus.iss_valid && ((|port_hazard) || long_block);
    accept_long = bus.iss_valid && !stall && bus.iss_long;

    pending_d = pending_q;
    if (bus.wb_en) begin
      pending_d[bus.wb_addr] = 1'b0;
    end
    if (accept_long && (bus.iss_dst != ZERO_REG)) begin
      pending_d[bus.iss_dst] = 1'b1;
    end
    pending_d[0] = 1'b0;

    pend_cnt_d = pend_cnt_q;
    if (accept_long && !bus.wb_en) begin
      pend_cnt_d = pend_cnt_q + 1'b1;
    end else if (!accept_long && bus.wb_en && (pend_cnt_q != '0)) begin
      pend_cnt_d = pend_cnt_q - 1'b1;
    end

    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      pend_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      pend_cnt_q     <= pend_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.pend_cnt     = pend_cnt_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule
